// File: rtl/cobs_pkg.sv
// Constants and state type shared by the COBS encoder and decoder.
// The decoder walks CODE -> DATA per group and parks in SKIP after an overflow.
package cobs_pkg;

    localparam logic [7:0] COBS_DELIM    = 8'h00;
    localparam logic [7:0] COBS_MAX_CODE = 8'hFF;

    typedef enum logic [1:0] {
        CODE = 2'd0,
        DATA = 2'd1,
        SKIP = 2'd2
    } cobs_dec_state_t;

endpackage

// File: rtl/axis_cobs_decoder.sv
// COBS byte-stream decoder: raw uart rx bytes in, decoded AXI-Stream frames out.
// tlast marks the final byte of a frame and tuser flags truncation/overflow on that beat.
module axis_cobs_decoder
    import cobs_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1500,
    parameter int LEN_WIDTH     = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       frame_done,
    output logic       decode_error
);

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_FRAME_LEN);
    localparam logic [LEN_WIDTH-1:0] LEN_SAT = LEN_WIDTH'(MAX_FRAME_LEN + 1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    cobs_dec_state_t        r_state;
    logic [7:0]             r_rem;
    logic [LEN_WIDTH-1:0]   r_len;
    logic                   r_code_ff;
    logic                   r_zero_pending;
    logic [7:0]             r_held;
    logic                   r_held_valid;
    logic [7:0]             r_out_data;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_out_user;
    logic                   r_frame_done;
    logic                   r_decode_error;

    cobs_dec_state_t        w_state_nxt;
    logic [7:0]             w_rem_nxt;
    logic [LEN_WIDTH-1:0]   w_len_nxt;
    logic                   w_code_ff_nxt;
    logic                   w_zero_pend_nxt;
    logic [7:0]             w_held_nxt;
    logic                   w_held_vld_nxt;
    logic                   w_accept;
    logic                   w_push;
    logic [7:0]             w_push_byte;
    logic                   w_flush;
    logic                   w_flush_err;
    logic                   w_load;
    logic [7:0]             w_load_data;
    logic                   w_load_last;
    logic                   w_load_user;
    logic                   w_frame_done;
    logic                   w_decode_error;

    // Accept whenever the output register is empty or retiring this cycle.
    assign s_axis_tready = !r_out_valid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    assign m_axis_tdata  = r_out_data;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tuser  = r_out_user;
    assign frame_done    = r_frame_done;
    assign decode_error  = r_decode_error;

    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        w_len_nxt       = r_len;
        w_code_ff_nxt   = r_code_ff;
        w_zero_pend_nxt = r_zero_pending;
        w_held_nxt      = r_held;
        w_held_vld_nxt  = r_held_valid;
        w_push          = 1'b0;
        w_push_byte     = COBS_DELIM;
        w_flush         = 1'b0;
        w_flush_err     = 1'b0;
        w_load          = 1'b0;
        w_load_data     = r_held;
        w_load_last     = 1'b0;
        w_load_user     = 1'b0;
        w_frame_done    = 1'b0;
        w_decode_error  = 1'b0;

        if (w_accept) begin
            case (r_state)
                CODE: begin
                    if (s_axis_tdata == COBS_DELIM) begin
                        w_flush = 1'b1;
                    end else begin
                        // The previous group's implied zero is only real once another group follows.
                        w_push          = r_zero_pending;
                        w_push_byte     = COBS_DELIM;
                        w_zero_pend_nxt = 1'b0;
                        w_rem_nxt       = s_axis_tdata - 8'd1;
                        w_code_ff_nxt   = (s_axis_tdata == COBS_MAX_CODE);
                        if (w_rem_nxt == 8'd0) begin
                            w_zero_pend_nxt = !w_code_ff_nxt;
                        end else begin
                            w_state_nxt = DATA;
                        end
                    end
                end
                DATA: begin
                    if (s_axis_tdata == COBS_DELIM) begin
                        w_decode_error = 1'b1;
                        w_flush        = 1'b1;
                        w_flush_err    = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_push_byte = s_axis_tdata;
                        if (r_rem != 8'd0) begin
                            w_rem_nxt = r_rem - 8'd1;
                        end
                        if (r_rem == 8'd1) begin
                            w_zero_pend_nxt = !r_code_ff;
                            w_state_nxt     = CODE;
                        end
                    end
                end
                SKIP: begin
                    if (s_axis_tdata == COBS_DELIM) begin
                        w_state_nxt     = CODE;
                        w_held_vld_nxt  = 1'b0;
                        w_zero_pend_nxt = 1'b0;
                        w_len_nxt       = '0;
                        w_rem_nxt       = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt = CODE;
                end
            endcase
        end

        if (w_push) begin
            if (r_len >= LEN_MAX) begin
                // Overflow: drop the byte, close the frame on the held byte, discard until delimiter.
                w_decode_error  = 1'b1;
                w_load          = r_held_valid;
                w_load_last     = 1'b1;
                w_load_user     = 1'b1;
                w_frame_done    = r_held_valid;
                w_held_vld_nxt  = 1'b0;
                w_zero_pend_nxt = 1'b0;
                w_rem_nxt       = 8'd0;
                w_len_nxt       = LEN_SAT;
                w_state_nxt     = SKIP;
            end else begin
                w_load         = r_held_valid;
                w_held_nxt     = w_push_byte;
                w_held_vld_nxt = 1'b1;
                w_len_nxt      = r_len + LEN_ONE;
            end
        end

        if (w_flush) begin
            w_load          = r_held_valid;
            w_load_last     = 1'b1;
            w_load_user     = w_flush_err;
            w_frame_done    = r_held_valid;
            w_held_vld_nxt  = 1'b0;
            w_zero_pend_nxt = 1'b0;
            w_len_nxt       = '0;
            w_rem_nxt       = 8'd0;
            w_state_nxt     = CODE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= CODE;
            r_rem          <= 8'd0;
            r_len          <= '0;
            r_code_ff      <= 1'b0;
            r_zero_pending <= 1'b0;
            r_held         <= 8'd0;
            r_held_valid   <= 1'b0;
            r_out_data     <= 8'd0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_out_user     <= 1'b0;
            r_frame_done   <= 1'b0;
            r_decode_error <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_rem          <= w_rem_nxt;
            r_len          <= w_len_nxt;
            r_code_ff      <= w_code_ff_nxt;
            r_zero_pending <= w_zero_pend_nxt;
            r_held         <= w_held_nxt;
            r_held_valid   <= w_held_vld_nxt;
            r_frame_done   <= w_frame_done;
            r_decode_error <= w_decode_error;
            if (w_load) begin
                r_out_data  <= w_load_data;
                r_out_last  <= w_load_last;
                r_out_user  <= w_load_user;
                r_out_valid <= 1'b1;
            end else if (m_axis_tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
